// File: rtl/k007232_rom_arb.sv
// Sample-ROM read arbiter for 007232 PCM channels: per-requester one-byte cache,
// round-robin grant, one outstanding memory read, sticky timeout error.
module k007232_rom_arb #(
   parameter int NREQ    = 2,
   parameter int AW      = 17,
   parameter int ROM_AW  = 22,
   parameter int TIMEOUT = 255
) (
   input  logic                   CLK,
   input  logic                   NRES,
   input  logic [NREQ*AW-1:0]     REQ_ADDR,
   input  logic [NREQ*ROM_AW-1:0] REQ_BASE,
   input  logic                   FLUSH,
   output logic [NREQ*8-1:0]      REQ_DATA,
   output logic [NREQ-1:0]        REQ_VALID,
   output logic                   MEM_REQ,
   output logic [ROM_AW-1:0]      MEM_ADDR,
   input  logic                   MEM_ACK,
   input  logic [7:0]             MEM_DATA,
   output logic                   TO_ERR
);

   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

   state_t            state_r;
   logic [GW-1:0]     gnt_r;
   logic [GW-1:0]     rr_r;
   logic [9:0]        cnt_r;
   logic              flushed_r;
   logic [NREQ-1:0]   tv_r;
   logic [ROM_AW-1:0] tag_r [NREQ];
   logic [ROM_AW-1:0] fa_s  [NREQ];
   logic [NREQ-1:0]   pend_s;
   logic [GW-1:0]     gnt_s;
   logic [GW-1:0]     rr_next_s;
   logic              any_s;

   // Full ROM address per requester and cache hit status.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         fa_s[i]      = REQ_BASE[i*ROM_AW +: ROM_AW] + ROM_AW'(REQ_ADDR[i*AW +: AW]);
         REQ_VALID[i] = tv_r[i] & (tag_r[i] == fa_s[i]);
      end
      pend_s = ~REQ_VALID;
   end

   // Circular search for the first pending requester at or after the RR pointer.
   always_comb begin
      int idx;
      idx   = 0;
      gnt_s = rr_r;
      any_s = 1'b0;
      // Walk backwards so the closest pending index is the last one written.
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx   = (int'(rr_r) + k) % NREQ;
         gnt_s = pend_s[idx] ? GW'(idx) : gnt_s;
         any_s = any_s | pend_s[idx];
      end
   end

   assign rr_next_s = (gnt_r == GW'(NREQ - 1)) ? '0 : gnt_r + GW'(1);

   // Arbitration FSM, cache update and memory handshake.
   always_ff @(posedge CLK or negedge NRES) begin
      if (!NRES) begin
         state_r   <= ST_IDLE;
         gnt_r     <= '0;
         rr_r      <= '0;
         cnt_r     <= 10'd0;
         flushed_r <= 1'b0;
         tv_r      <= '0;
         for (int i = 0; i < NREQ; i++) tag_r[i] <= '0;
         REQ_DATA  <= '0;
         MEM_REQ   <= 1'b0;
         MEM_ADDR  <= '0;
         TO_ERR    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (any_s && !FLUSH) begin
                  MEM_ADDR  <= fa_s[gnt_s];
                  MEM_REQ   <= 1'b1;
                  gnt_r     <= gnt_s;
                  cnt_r     <= 10'd0;
                  flushed_r <= 1'b0;
                  state_r   <= ST_WAIT;
               end else begin
                  MEM_REQ <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (MEM_ACK) begin
                  REQ_DATA[int'(gnt_r)*8 +: 8] <= MEM_DATA;
                  tag_r[gnt_r] <= MEM_ADDR;
                  if (!FLUSH && !flushed_r) begin
                     tv_r[gnt_r] <= 1'b1;
                  end else begin
                     tv_r[gnt_r] <= 1'b0;
                  end
                  MEM_REQ <= 1'b0;
                  rr_r    <= rr_next_s;
                  state_r <= ST_IDLE;
               end else if (cnt_r == TO_LAST) begin
                  MEM_REQ <= 1'b0;
                  TO_ERR  <= 1'b1;
                  rr_r    <= rr_next_s;
                  state_r <= ST_IDLE;
               end else begin
                  cnt_r <= cnt_r + 10'd1;
               end
            end
            default: begin
               MEM_REQ <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
         // Flush overrides any tag-valid set above and poisons an in-flight read.
         if (FLUSH) begin
            tv_r      <= '0;
            flushed_r <= 1'b1;
         end else begin
            flushed_r <= flushed_r & (state_r == ST_WAIT);
         end
      end
   end

endmodule

// File: tb/tb_k007232_rom_arb.sv
// Bench for k007232_rom_arb: directed vector table, corner sequences, and
// randomized transactions checked against a transaction-level cache model.
module tb_k007232_rom_arb;

   logic        CLK;
   logic        NRES;
   logic        FLUSH;
   logic        MEM_ACK;
   logic [7:0]  MEM_DATA;
   logic [33:0] REQ_ADDR;
   logic [43:0] REQ_BASE;
   logic [15:0] REQ_DATA;
   logic [1:0]  REQ_VALID;
   logic        MEM_REQ;
   logic [21:0] MEM_ADDR;
   logic        TO_ERR;

   logic [16:0] a [2];
   logic [21:0] b [2];
   assign REQ_ADDR = {a[1], a[0]};
   assign REQ_BASE = {b[1], b[0]};

   int tests;
   int fails;

   // Reference model state
   logic [21:0] mtag  [2];
   logic [7:0]  mdata [2];
   logic [1:0]  mv;
   int          rr;
   logic        terr;

   k007232_rom_arb #(.NREQ(2), .AW(17), .ROM_AW(22), .TIMEOUT(4)) dut (
      .CLK(CLK), .NRES(NRES), .REQ_ADDR(REQ_ADDR), .REQ_BASE(REQ_BASE),
      .FLUSH(FLUSH), .REQ_DATA(REQ_DATA), .REQ_VALID(REQ_VALID),
      .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK),
      .MEM_DATA(MEM_DATA), .TO_ERR(TO_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic [16:0] a0, a1;
      logic [21:0] b0, b1;
      logic [21:0] ea;
      logic [7:0]  d;
      logic [1:0]  ev;
      logic [15:0] erd;
   } vec_t;
   vec_t vecs [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic respond(input int lat, input logic [7:0] d);
      for (int k = 1; k < lat; k++) tick();
      MEM_ACK  = 1'b1;
      MEM_DATA = d;
      tick();
      MEM_ACK  = 1'b0;
      chk("req_drop", {31'd0, MEM_REQ}, 32'd0);
   endtask

   task automatic xact(input string nm, input logic [21:0] ea, input logic [7:0] d);
      tick();
      chk({nm, "_req"}, {31'd0, MEM_REQ}, 32'd1);
      chk({nm, "_addr"}, {10'd0, MEM_ADDR}, {10'd0, ea});
      respond(3, d);
   endtask

   function automatic logic [21:0] fa(input int i);
      logic [22:0] s;
      s = {1'b0, b[i]} + {6'd0, a[i]};
      return s[21:0];
   endfunction

   function automatic logic [1:0] mvalid();
      logic [1:0] r;
      for (int i = 0; i < 2; i++) r[i] = mv[i] && (mtag[i] == fa(i));
      return r;
   endfunction

   logic [1:0]  pend;
   logic [21:0] ea;
   logic [7:0]  d;
   int          g, lat, flk, r;
   logic        flushed;

   initial begin
      tests = 0; fails = 0;
      FLUSH = 1'b0; MEM_ACK = 1'b0; MEM_DATA = 8'h00;
      a[0] = 17'h10; a[1] = 17'h20; b[0] = 22'h0; b[1] = 22'h0;
      NRES = 1'b0;

      vecs[0] = '{17'h10,    17'h20, 22'h0,      22'h0,      22'h000010, 8'hA5, 2'b01, 16'h00A5};
      vecs[1] = '{17'h10,    17'h20, 22'h0,      22'h0,      22'h000020, 8'h5A, 2'b11, 16'h5AA5};
      vecs[2] = '{17'h11,    17'h20, 22'h0,      22'h0,      22'h000011, 8'h11, 2'b11, 16'h5A11};
      vecs[3] = '{17'h12,    17'h21, 22'h0,      22'h0,      22'h000021, 8'h21, 2'b10, 16'h2111};
      vecs[4] = '{17'h12,    17'h21, 22'h0,      22'h0,      22'h000012, 8'h12, 2'b11, 16'h2112};
      vecs[5] = '{17'h20,    17'h21, 22'h3FFFF0, 22'h0,      22'h000010, 8'h77, 2'b11, 16'h2177};
      vecs[6] = '{17'h20,    17'h21, 22'h3FFFF0, 22'h100000, 22'h100021, 8'h3C, 2'b11, 16'h3C77};
      vecs[7] = '{17'h1FFFF, 17'h21, 22'h3FFFFF, 22'h100000, 22'h01FFFE, 8'hC3, 2'b11, 16'h3CC3};

      repeat (2) @(posedge CLK);
      #1;
      chk("rst_memreq", {31'd0, MEM_REQ}, 32'd0);
      chk("rst_memaddr", {10'd0, MEM_ADDR}, 32'd0);
      chk("rst_data", {16'd0, REQ_DATA}, 32'd0);
      chk("rst_valid", {30'd0, REQ_VALID}, 32'd0);
      chk("rst_toerr", {31'd0, TO_ERR}, 32'd0);
      NRES = 1'b1;

      for (int v = 0; v < 8; v++) begin
         a[0] = vecs[v].a0; a[1] = vecs[v].a1; b[0] = vecs[v].b0; b[1] = vecs[v].b1;
         xact($sformatf("vec%0d", v), vecs[v].ea, vecs[v].d);
         chk($sformatf("vec%0d_valid", v), {30'd0, REQ_VALID}, {30'd0, vecs[v].ev});
         chk($sformatf("vec%0d_data", v), {16'd0, REQ_DATA}, {16'd0, vecs[v].erd});
      end

      // Reset in the middle of a read
      a[0] = 17'h15;
      tick();
      chk("mid_req", {31'd0, MEM_REQ}, 32'd1);
      chk("mid_addr", {10'd0, MEM_ADDR}, 32'h000014);
      NRES = 1'b0;
      #1;
      chk("mid_rst_req", {31'd0, MEM_REQ}, 32'd0);
      chk("mid_rst_valid", {30'd0, REQ_VALID}, 32'd0);
      chk("mid_rst_data", {16'd0, REQ_DATA}, 32'd0);
      b[0] = 22'h0; b[1] = 22'h0; a[0] = 17'h10; a[1] = 17'h20;
      tick();
      NRES = 1'b1;

      // Address moves while its read is outstanding
      tick();
      chk("chg_req", {31'd0, MEM_REQ}, 32'd1);
      chk("chg_addr", {10'd0, MEM_ADDR}, 32'h10);
      a[0] = 17'h11;
      respond(3, 8'hE1);
      chk("chg_valid", {30'd0, REQ_VALID}, 32'd0);
      chk("chg_data", {24'd0, REQ_DATA[7:0]}, 32'hE1);
      xact("chg_other", 22'h20, 8'hE2);
      xact("chg_refetch", 22'h11, 8'hE3);
      chk("chg_valid2", {30'd0, REQ_VALID}, 32'd3);

      // Timeout, then ACK pulse while idle
      a[0] = 17'h40; a[1] = 17'h50;
      tick();
      chk("to_addr", {10'd0, MEM_ADDR}, 32'h50);
      for (int k = 1; k < 4; k++) begin
         tick();
         chk("to_hold", {31'd0, MEM_REQ}, 32'd1);
      end
      tick();
      chk("to_drop", {31'd0, MEM_REQ}, 32'd0);
      chk("to_err", {31'd0, TO_ERR}, 32'd1);
      MEM_ACK = 1'b1; MEM_DATA = 8'hFF;
      tick();
      MEM_ACK = 1'b0;
      chk("to_next_req", {31'd0, MEM_REQ}, 32'd1);
      chk("to_next_addr", {10'd0, MEM_ADDR}, 32'h40);
      chk("idle_ack_data", {16'd0, REQ_DATA}, 32'hE2E3);
      respond(2, 8'h40);
      xact("to_retry", 22'h50, 8'h50);
      chk("to_valid", {30'd0, REQ_VALID}, 32'd3);
      chk("to_sticky", {31'd0, TO_ERR}, 32'd1);
      chk("to_data", {16'd0, REQ_DATA}, 32'h5040);

      // Flush during an in-flight read, then flush held in idle
      a[0] = 17'h41;
      tick();
      chk("fl_addr", {10'd0, MEM_ADDR}, 32'h41);
      FLUSH = 1'b1;
      tick();
      FLUSH = 1'b0;
      chk("fl_valid", {30'd0, REQ_VALID}, 32'd0);
      tick();
      MEM_ACK = 1'b1; MEM_DATA = 8'h99;
      tick();
      MEM_ACK = 1'b0;
      chk("fl_drop", {31'd0, MEM_REQ}, 32'd0);
      chk("fl_valid2", {30'd0, REQ_VALID}, 32'd0);
      chk("fl_data", {24'd0, REQ_DATA[7:0]}, 32'h99);
      FLUSH = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("fl_nogrant", {31'd0, MEM_REQ}, 32'd0);
      end
      FLUSH = 1'b0;
      xact("fl_refetch1", 22'h50, 8'hB1);
      xact("fl_refetch0", 22'h41, 8'hB0);
      chk("fl_valid3", {30'd0, REQ_VALID}, 32'd3);
      chk("fl_data2", {16'd0, REQ_DATA}, 32'hB1B0);

      // Randomized transactions against the cache model
      NRES = 1'b0;
      #1;
      mv = 2'b00; rr = 0; terr = 1'b0;
      mtag[0] = 22'h0; mtag[1] = 22'h0; mdata[0] = 8'h00; mdata[1] = 8'h00;
      a[0] = 17'($urandom); a[1] = 17'($urandom); b[0] = 22'h0; b[1] = 22'h0;
      tick();
      NRES = 1'b1;
      for (int it = 0; it < 200; it++) begin
         for (int i = 0; i < 2; i++) begin
            r = $urandom_range(0, 7);
            if (r < 4) a[i] = a[i] + 17'd1;
            else if (r == 4) a[i] = 17'($urandom);
         end
         if ($urandom_range(0, 15) == 0) b[$urandom_range(0, 1)] = 22'($urandom);
         pend = ~mvalid();
         if (pend == 2'b00) begin
            tick();
            chk("r_idle", {31'd0, MEM_REQ}, 32'd0);
            continue;
         end
         g = -1;
         for (int k = 0; k < 2; k++) begin
            if (g < 0 && pend[(rr + k) % 2]) g = (rr + k) % 2;
         end
         ea = fa(g);
         tick();
         chk("r_req", {31'd0, MEM_REQ}, 32'd1);
         chk("r_addr", {10'd0, MEM_ADDR}, {10'd0, ea});
         lat = $urandom_range(1, 6);
         flk = $urandom_range(0, 8);
         d = 8'($urandom);
         flushed = 1'b0;
         if ($urandom_range(0, 3) == 0) a[g] = 17'($urandom);
         for (int k = 1; k <= 4; k++) begin
            if (k == flk) begin FLUSH = 1'b1; flushed = 1'b1; mv = 2'b00; end
            if (k == lat) begin MEM_ACK = 1'b1; MEM_DATA = d; end
            tick();
            FLUSH = 1'b0;
            MEM_ACK = 1'b0;
            if (k == lat) break;
            if (k < 4) chk("r_hold", {31'd0, MEM_REQ}, 32'd1);
         end
         if (lat <= 4) begin
            mdata[g] = d;
            mtag[g]  = ea;
            mv[g]    = !flushed;
         end else begin
            terr = 1'b1;
         end
         rr = (g + 1) % 2;
         chk("r_drop", {31'd0, MEM_REQ}, 32'd0);
         chk("r_toerr", {31'd0, TO_ERR}, {31'd0, terr});
         chk("r_data", {16'd0, REQ_DATA}, {16'd0, mdata[1], mdata[0]});
         chk("r_valid", {30'd0, REQ_VALID}, {30'd0, mvalid()});
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
